// File: rtl/huffman_packer.sv
// Huffman bit packer: maps symbols 1..6 through a latched code table and packs codes MSB-first into bytes.
// Latency: a byte completed by a symbol accepted at edge E is presented after edge E+1; flush emits one byte per cycle.
// Backpressure: none downstream; sym_ready is held high for the whole RUN phase and the 16-bit buffer never overflows.
module huffman_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        sym_valid,
  input  logic [7:0]  sym_data,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        done,
  output logic [15:0] byte_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched code table: code already masked, length derived from the mask.
  logic [5:0][7:0] code_tab;
  logic [5:0][3:0] len_tab;

  // MSB-aligned bit buffer; valid bits occupy bit_buf[15 -: bit_cnt], everything below is zero.
  logic [15:0] bit_buf;
  logic [4:0]  bit_cnt;

  logic [7:0]  sel_code;
  logic [3:0]  sel_len;
  logic        accept;
  logic        pop;
  logic        append;
  logic [15:0] base_buf;
  logic [4:0]  base_cnt;
  logic [15:0] sym_aligned;
  logic [15:0] run_buf;
  logic [4:0]  run_cnt;
  logic        flush_emit;
  logic        flush_last;
  logic [4:0]  flush_cnt;
  logic [15:0] byte_cnt_inc;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  assign sym_ready = (state == RUN);
  assign done      = (state == DONE);
  assign accept    = sym_valid && sym_ready;

  // Look up code and length for the incoming symbol; out-of-range symbols contribute nothing.
  always_comb begin
    sel_code = '0;
    sel_len  = '0;
    case (sym_data)
      8'd1: begin sel_code = code_tab[0]; sel_len = len_tab[0]; end
      8'd2: begin sel_code = code_tab[1]; sel_len = len_tab[1]; end
      8'd3: begin sel_code = code_tab[2]; sel_len = len_tab[2]; end
      8'd4: begin sel_code = code_tab[3]; sel_len = len_tab[3]; end
      8'd5: begin sel_code = code_tab[4]; sel_len = len_tab[4]; end
      8'd6: begin sel_code = code_tab[5]; sel_len = len_tab[5]; end
      default: ;
    endcase
  end

  // RUN datapath: pop a full byte first, then append the accepted code behind the remaining bits.
  always_comb begin
    pop         = (bit_cnt >= 5'd8);
    base_buf    = pop ? {bit_buf[7:0], 8'h00} : bit_buf;
    base_cnt    = pop ? (bit_cnt - 5'd8) : bit_cnt;
    append      = accept && (sel_len != 4'd0);
    // Left-justify the right-aligned code to bit 15, then slide it behind the existing bits.
    sym_aligned = ({sel_code, 8'h00} << (4'd8 - sel_len)) >> base_cnt;
    run_buf     = append ? (base_buf | sym_aligned) : base_buf;
    run_cnt     = append ? (base_cnt + {1'b0, sel_len}) : base_cnt;
  end

  // FLUSH datapath: drain up to eight bits per cycle; the byte that empties the buffer is the last one.
  always_comb begin
    flush_emit = (bit_cnt != 5'd0);
    flush_last = (bit_cnt <= 5'd8);
    flush_cnt  = flush_last ? 5'd0 : (bit_cnt - 5'd8);
  end

  assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : (byte_cnt + 16'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (code_valid) state_nxt = RUN;
      RUN:     if (accept && sym_last) state_nxt = FLUSH;
      FLUSH:   if (bit_cnt == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Code table, bit buffer, output byte register and frame byte counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      code_tab  <= '0;
      len_tab   <= '0;
      bit_buf   <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            code_tab[0] <= HC1 & M1;
            code_tab[1] <= HC2 & M2;
            code_tab[2] <= HC3 & M3;
            code_tab[3] <= HC4 & M4;
            code_tab[4] <= HC5 & M5;
            code_tab[5] <= HC6 & M6;
            len_tab[0]  <= popcount8(M1);
            len_tab[1]  <= popcount8(M2);
            len_tab[2]  <= popcount8(M3);
            len_tab[3]  <= popcount8(M4);
            len_tab[4]  <= popcount8(M5);
            len_tab[5]  <= popcount8(M6);
            bit_buf     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
          end
        end
        RUN: begin
          if (pop) begin
            out_valid <= 1'b1;
            out_data  <= bit_buf[15:8];
            byte_cnt  <= byte_cnt_inc;
          end
          bit_buf <= run_buf;
          bit_cnt <= run_cnt;
        end
        FLUSH: begin
          if (flush_emit) begin
            out_valid <= 1'b1;
            out_data  <= bit_buf[15:8];
            out_last  <= flush_last;
            byte_cnt  <= byte_cnt_inc;
            bit_buf   <= {bit_buf[7:0], 8'h00};
            bit_cnt   <= flush_cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Bench for huffman_packer: directed frames plus random tables/frames against a bit-queue packing model.
// Latency: expected emission edge of each byte is derived from the symbol acceptance edges.
// Backpressure: sym_ready must stay high throughout every frame.
module tb_huffman_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  t_hc [6];
  logic [7:0]  t_m  [6];
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = 8'h00;
  logic        sym_last = 1'b0;
  logic        sym_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;
  logic [15:0] byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_bad = 0;

  logic [7:0] got_q [$];
  logic       got_last [$];
  int         got_cyc [$];

  logic [7:0] r_code [6];
  int         r_len [6];
  logic [7:0] fr_sym [$];
  int         fr_gap [$];
  logic       cv_in_run = 1'b0;

  huffman_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(t_hc[0]), .HC2(t_hc[1]), .HC3(t_hc[2]), .HC4(t_hc[3]), .HC5(t_hc[4]), .HC6(t_hc[5]),
    .M1(t_m[0]), .M2(t_m[1]), .M3(t_m[2]), .M4(t_m[3]), .M5(t_m[4]), .M6(t_m[5]),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .done(done), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_q.push_back(out_data);
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
    if (out_last === 1'b1 && out_valid !== 1'b1) last_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tab(input int k, input logic [7:0] hc, input logic [7:0] m);
    t_hc[k] = hc;
    t_m[k]  = m;
  endtask

  task automatic set_ref_table();
    for (int k = 0; k < 6; k++) set_tab(k, 8'h00, 8'h00);
    set_tab(0, 8'h00, 8'h01);
    set_tab(1, 8'h02, 8'h03);
    set_tab(2, 8'h06, 8'h07);
  endtask

  // Pulse code_valid for one edge and record the table the model should use.
  task automatic load_table();
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      r_code[k] = t_hc[k] & t_m[k];
      r_len[k]  = 0;
      for (int b = 0; b < 8; b++) r_len[k] += int'(t_m[k][b]);
    end
  endtask

  task automatic push_sym(input logic [7:0] s, input int gap);
    fr_sym.push_back(s);
    fr_gap.push_back(gap);
  endtask

  // Drive fr_sym as one frame, wait for done, and compare bytes, flags, timing and byte_cnt with the model.
  task automatic run_frame(input string tag);
    int         acc [$];
    logic       bits [$];
    int         exp_cyc [$];
    int         ready_bad;
    int         nfull;
    int         nbytes;
    int         n;
    int         s;
    int         w;
    logic [7:0] eb;
    ready_bad = 0;
    nfull = 0;
    n = fr_sym.size();
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'b0;
      for (int g = 0; g < fr_gap[i]; g++) begin
        if (sym_ready !== 1'b1) ready_bad++;
        tick();
      end
      sym_valid = 1'b1;
      sym_data  = fr_sym[i];
      sym_last  = (i == n - 1);
      if (i == 0 && cv_in_run) code_valid = 1'b1;
      if (sym_ready !== 1'b1) ready_bad++;
      tick();
      acc.push_back(cyc);
      code_valid = 1'b0;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    sym_data  = 8'h00;

    // Model: concatenate code bits, cut into bytes; a byte is due the edge after the symbol that completes it.
    for (int i = 0; i < n; i++) begin
      s = int'(fr_sym[i]);
      if (s >= 1 && s <= 6) begin
        for (int b = r_len[s-1] - 1; b >= 0; b--) bits.push_back(r_code[s-1][b]);
      end
      while (bits.size() >= 8 * (nfull + 1)) begin
        exp_cyc.push_back(acc[i] + 1);
        nfull++;
      end
    end
    nbytes = (bits.size() + 7) / 8;
    if (nbytes > nfull) begin
      if (nfull > 0 && exp_cyc[nfull-1] + 1 > acc[n-1] + 1) exp_cyc.push_back(exp_cyc[nfull-1] + 1);
      else exp_cyc.push_back(acc[n-1] + 1);
    end

    w = 0;
    while (done !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " byte_cnt"}, 32'(byte_cnt), 32'(nbytes));
    check({tag, " nbytes"}, 32'(got_q.size()), 32'(nbytes));
    for (int j = 0; j < nbytes && j < got_q.size(); j++) begin
      eb = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (8 * j + b < bits.size()) eb[7-b] = bits[8*j+b];
      end
      check($sformatf("%s byte%0d", tag, j), 32'(got_q[j]), 32'(eb));
      check($sformatf("%s last%0d", tag, j), 32'(got_last[j]), 32'(j == nbytes - 1));
      check($sformatf("%s edge%0d", tag, j), 32'(got_cyc[j]), 32'(exp_cyc[j]));
    end
    check({tag, " sym_ready"}, 32'(ready_bad), 32'd0);
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " byte_cnt hold"}, 32'(byte_cnt), 32'(nbytes));
    fr_sym.delete();
    fr_gap.delete();
  endtask

  initial begin
    int len;
    int nsym;
    for (int k = 0; k < 6; k++) set_tab(k, 8'h00, 8'h00);

    // Reset state.
    reset = 1'b0;
    tick();
    tick();
    check("rst sym_ready", 32'(sym_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst byte_cnt", 32'(byte_cnt), 32'd0);

    // code_valid accepted on the first edge after release.
    set_ref_table();
    reset = 1'b1;
    load_table();
    check("first cv sym_ready", 32'(sym_ready), 32'd1);

    push_sym(8'd1, 0); push_sym(8'd2, 0); push_sym(8'd3, 0);
    run_frame("basic");
    if (got_q.size() > 0) check("basic 0x58", 32'(got_q[0]), 32'h58);

    load_table();
    for (int i = 0; i < 8; i++) push_sym(8'd1, 0);
    run_frame("eight ones");

    set_tab(3, 8'hA5, 8'hFF);
    load_table();
    push_sym(8'd4, 0); push_sym(8'd4, 0); push_sym(8'd4, 0);
    run_frame("full bytes");
    if (got_cyc.size() == 3) check("full bytes consecutive", 32'(got_cyc[2] - got_cyc[0]), 32'd2);

    set_ref_table();
    load_table();
    push_sym(8'h07, 0); push_sym(8'h00, 0); push_sym(8'd1, 0);
    run_frame("invalid syms");

    // code_valid during RUN with a different table must be ignored.
    load_table();
    for (int k = 0; k < 6; k++) set_tab(k, 8'hFF, 8'hFF);
    cv_in_run = 1'b1;
    push_sym(8'd1, 0); push_sym(8'd2, 1); push_sym(8'd3, 0);
    run_frame("cv in run");
    cv_in_run = 1'b0;
    if (got_q.size() > 0) check("cv in run 0x58", 32'(got_q[0]), 32'h58);

    set_ref_table();
    load_table();
    push_sym(8'h00, 0);
    run_frame("empty frame");

    // Reset mid-RUN with five bits buffered.
    load_table();
    got_q.delete();
    sym_valid = 1'b1; sym_data = 8'd2; tick();
    sym_data = 8'd3; tick();
    sym_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("midrst sym_ready", 32'(sym_ready), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", 32'(out_data), 32'd0);
    check("midrst out_last", 32'(out_last), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst byte_cnt", 32'(byte_cnt), 32'd0);
    tick();
    check("midrst no byte", 32'(got_q.size()), 32'd0);
    reset = 1'b1;
    load_table();
    push_sym(8'd1, 0); push_sym(8'd2, 0); push_sym(8'd3, 0);
    run_frame("after midrst");

    // Random tables and frames with occasional idle gaps.
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 6; k++) begin
        len = $urandom_range(0, 8);
        set_tab(k, 8'($urandom), 8'((9'h001 << len) - 9'h001));
      end
      load_table();
      nsym = $urandom_range(1, 16);
      for (int i = 0; i < nsym; i++) begin
        if ($urandom_range(0, 9) < 8) push_sym(8'($urandom_range(1, 6)), 0);
        else push_sym(8'($urandom), 0);
        if ($urandom_range(0, 3) == 0) fr_gap[i] = $urandom_range(1, 2);
      end
      run_frame($sformatf("rand%0d", f));
    end

    check("out_last without out_valid", 32'(last_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huffman_packer.md
HUFFMAN_PACKER -- requirements
Module: huffman_packer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; reset is sampled only on the rising clock edge.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-low reset (0 = reset).
REQ-004 Ports: code_valid  input  1  one-cycle pulse that loads the code table.
REQ-005 Ports: HC1..HC6  input  8 each  right-aligned Huffman code per symbol; M1..M6  input  8 each  mask per symbol, contiguous low-order ones.
REQ-006 Ports: sym_valid  input  1; sym_data  input  8  symbol value; sym_last  input  1  marks the final symbol; sym_ready  output  1.
REQ-007 Ports: out_valid  output  1; out_data  output  8  packed byte, MSB first; out_last  output  1  marks the final byte.
REQ-008 Ports: done  output  1  one-cycle end-of-frame pulse; byte_cnt  output  16  number of bytes emitted in the current frame.

Function
REQ-009 States SHALL be IDLE, RUN, FLUSH and DONE.
REQ-010 IDLE: code_valid=1 SHALL latch HCk&Mk and len_k = popcount(Mk) (0..8) for k=1..6, then go to RUN; code_valid SHALL be ignored in every other state.
REQ-011 sym_ready SHALL be 1 exactly while in RUN; a symbol is accepted on any edge with sym_valid=1 and sym_ready=1.
REQ-012 Accepted sym_data outside 1..6, or a symbol with len=0, SHALL contribute no bits but SHALL still honour sym_last.
REQ-013 Bit buffer: 16-bit register buf (MSB-aligned) and 5-bit count cnt (0..15); a code is appended MSB first directly after the existing valid bits.
REQ-014 Every RUN edge: pop = (cnt>=8); if pop, out_data<=buf[15:8], out_valid<=1, buf shifts left 8, cnt-=8; a symbol accepted on the same edge is appended after the shift.
REQ-015 out_valid SHALL be 0 on every edge where no byte is emitted; out_data SHALL hold its last value.
REQ-016 Latency: a byte completed by the symbol accepted at edge E SHALL be presented with out_valid=1 after edge E+1.
REQ-017 With len<=8 the buffer SHALL never overflow and input SHALL never be stalled in RUN.
REQ-018 Accepting a symbol with sym_last=1 SHALL move the block to FLUSH on that edge.
REQ-019 FLUSH: each edge with cnt>0 SHALL emit buf[15:8] (bits below cnt zero-padded) and subtract min(cnt,8); out_last=1 on the byte that brings cnt to 0.
REQ-020 FLUSH with cnt=0 SHALL go to DONE; a frame with zero total bits emits no byte and no out_last.
REQ-021 DONE SHALL assert done=1 for one cycle, then go to IDLE; byte_cnt SHALL hold its value until the next code_valid clears it to 0.
REQ-022 byte_cnt SHALL increment on each emitted byte and saturate at 16'hFFFF.
REQ-023 out_last SHALL be 1 only together with out_valid=1.

Reset
REQ-024 reset=0 at any edge, including mid-frame, SHALL force IDLE, clear the code table, buf, cnt and byte_cnt, and drive sym_ready, out_valid, out_data, out_last and done to 0.
REQ-025 The first code_valid after reset release SHALL be accepted on the first edge with reset=1.

Verification
REQ-026 Table {HC1=0,M1=1; HC2=2,M2=3; HC3=6,M3=7}; symbols 1,2,3 (last on 3) -> single byte 0x58 with out_last=1, then done, byte_cnt=1.
REQ-027 Eight back-to-back symbol 1 (len 1) with last on the 8th -> exactly one byte 0x00 with out_last=1, byte_cnt=1.
REQ-028 HC4=0xA5, M4=0xFF; symbols 4,4,4 continuous (last on 3rd) -> bytes 0xA5,0xA5,0xA5 on consecutive cycles, sym_ready never 0 in RUN, out_last on the 3rd byte.
REQ-029 Symbols 0x07,0x00,1 (table as REQ-026) -> 0x07 and 0x00 add no bits; output is a single byte 0x00 with out_last.
REQ-030 reset=0 asserted mid-RUN with cnt=5 -> next cycle IDLE, all outputs 0, no partial byte emitted; a fresh frame afterwards packs correctly.
REQ-031 code_valid pulsed in RUN with a different table -> ignored; output still encoded with the originally latched table.
